// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, registered instr with valid/ready to the decoder.
// Ack in cycle N -> instr_valid in N+1; instr/instr_pc held stable until accepted, no new request meanwhile.
module fetch_unit #(
  parameter int                ADDR_W   = 26,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              load_pc,
  input  logic [ADDR_W-1:0] load_pc_val
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic              ack_take;
  logic              accept;

  // Request is decoded from state so an async reset drops it immediately.
  assign imem_req  = (state == REQ);
  assign imem_addr = pc;
  assign ack_take  = (state == REQ) && imem_ack;
  assign accept    = (state == HOLD) && instr_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run) state_nxt = REQ;
      REQ:     if (imem_ack) state_nxt = HOLD;
      HOLD:    if (instr_ready) state_nxt = run ? REQ : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      if (ack_take) begin
        instr       <= imem_rdata;
        instr_pc    <= pc;
        instr_valid <= 1'b1;
      end
      // Redirect wins over sequential increment; increment wraps naturally.
      if (accept) begin
        pc          <= load_pc ? load_pc_val : pc + ADDR_W'(1);
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: table of fetch transactions plus hand-written run/reset sequences.
module tb_fetch_unit;

  localparam int AW = 26;
  localparam int DW = 32;
  localparam logic [AW-1:0] RPC = 26'h10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b1;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic [DW-1:0] imem_rdata = '0;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic          load_pc = 1'b0;
  logic [AW-1:0] load_pc_val = '0;

  fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .load_pc(load_pc), .load_pc_val(load_pc_val)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] rdata;
    int            ack_dly;
    int            rdy_dly;
    bit            load;
    logic [AW-1:0] load_val;
    bit            run_acc;
    logic [AW-1:0] exp_addr;
  } vec_t;

  typedef struct {
    logic [DW-1:0] ins;
    logic [AW-1:0] pc;
  } exp_t;

  vec_t vecs [9];
  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  bit   prev_vld = 1'b0;

  always @(negedge clk) begin
    if (instr_valid && !prev_vld) pulses++;
    prev_vld = instr_valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Entered and left at a negedge; acts as the memory and the decoder.
  task automatic run_vec(input vec_t v, input string tag);
    bit   ok;
    exp_t e;
    wait_req(ok);
    chk({tag, "_req_seen"}, 64'(ok), 64'd1);
    chk({tag, "_addr"}, 64'(imem_addr), 64'(v.exp_addr));
    for (int d = 0; d < v.ack_dly; d++) begin
      @(negedge clk);
      chk({tag, "_req_held"}, 64'(imem_req), 64'd1);
      chk({tag, "_addr_held"}, 64'(imem_addr), 64'(v.exp_addr));
    end
    imem_rdata = v.rdata;
    imem_ack   = 1'b1;
    sb.push_back('{ins: v.rdata, pc: v.exp_addr});
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    chk({tag, "_vld_after_ack"}, 64'(instr_valid), 64'd1);
    chk({tag, "_req_in_hold"}, 64'(imem_req), 64'd0);
    for (int r = 0; r < v.rdy_dly; r++) begin
      @(negedge clk);
      chk({tag, "_stall_instr"}, 64'(instr), 64'(v.rdata));
      chk({tag, "_stall_pc"}, 64'(instr_pc), 64'(v.exp_addr));
      chk({tag, "_stall_req"}, 64'(imem_req), 64'd0);
      chk({tag, "_stall_vld"}, 64'(instr_valid), 64'd1);
    end
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_instr"}, 64'(instr), 64'(e.ins));
      chk({tag, "_instr_pc"}, 64'(instr_pc), 64'(e.pc));
    end
    chk({tag, "_vld_at_accept"}, 64'(instr_valid), 64'd1);
    instr_ready = 1'b1;
    load_pc     = v.load;
    load_pc_val = v.load_val;
    run         = v.run_acc;
    @(negedge clk);
    instr_ready = 1'b0;
    load_pc     = 1'b1;
    load_pc_val = 26'h2AAAAAA;
    chk({tag, "_vld_drop"}, 64'(instr_valid), 64'd0);
    chk({tag, "_req_after_accept"}, 64'(imem_req), 64'(v.run_acc));
  endtask

  initial begin
    vecs[0] = '{32'h0422_1800, 0, 0, 1'b0, 26'h0,       1'b1, 26'h10};
    vecs[1] = '{32'h1111_1111, 3, 0, 1'b0, 26'h0,       1'b1, 26'h11};
    vecs[2] = '{32'h2222_2222, 0, 5, 1'b1, 26'h200,     1'b1, 26'h12};
    vecs[3] = '{32'h3333_3333, 1, 0, 1'b1, 26'h3FFFFFF, 1'b1, 26'h200};
    vecs[4] = '{32'h4444_4444, 0, 0, 1'b0, 26'h0,       1'b1, 26'h3FFFFFF};
    vecs[5] = '{32'h5555_5555, 0, 2, 1'b0, 26'h0,       1'b1, 26'h0};
    vecs[6] = '{32'h6666_6666, 2, 1, 1'b0, 26'h0,       1'b1, 26'h1};
    vecs[7] = '{32'h7777_7777, 0, 0, 1'b0, 26'h0,       1'b0, 26'h2};
    vecs[8] = '{32'h8888_8888, 0, 0, 1'b0, 26'h0,       1'b1, 26'h10};

    repeat (3) @(negedge clk);
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'(RPC));
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_instr_pc", 64'(instr_pc), 64'd0);
    chk("rst_vld", 64'(instr_valid), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    // run=0 at the last accept: stays idle until run returns.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_no_req", 64'(imem_req), 64'd0);
    end
    run = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("resume_req", 64'(imem_req), 64'd1);
    chk("resume_addr", 64'(imem_addr), 64'h3);

    // Reset mid-request; a late ack must be ignored.
    run   = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_req_drop", 64'(imem_req), 64'd0);
    chk("arst_addr", 64'(imem_addr), 64'(RPC));
    chk("arst_vld", 64'(instr_valid), 64'd0);
    @(negedge clk);
    rst_n      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    chk("late_ack_vld", 64'(instr_valid), 64'd0);
    chk("late_ack_req", 64'(imem_req), 64'd0);
    @(negedge clk);
    imem_ack = 1'b0;
    chk("late_ack_instr", 64'(instr), 64'd0);
    chk("late_ack_addr", 64'(imem_addr), 64'(RPC));
    run = 1'b1;
    @(negedge clk);
    run_vec(vecs[8], "v8");

    chk("vld_pulses", 64'(pulses), 64'd9);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
